// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared definitions for the compare/reduce unit
// Purpose: function codes, FSM state type, single-shot result constants and a
//          helper that classifies a function code as a reduction.
package cmp_pkg;

  localparam logic [2:0] CMP_NOP = 3'b000;
  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_GT  = 3'b010;
  localparam logic [2:0] CMP_LT  = 3'b011;
  localparam logic [2:0] CMP_NE  = 3'b100;
  localparam logic [2:0] CMP_MAX = 3'b101;
  localparam logic [2:0] CMP_MIN = 3'b110;
  localparam logic [2:0] CMP_RSV = 3'b111;

  // Single-shot result encodings (EQ and NE share the value 1).
  localparam int CMP_RES_EQ = 1;
  localparam int CMP_RES_GT = 2;
  localparam int CMP_RES_LT = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } cmp_state_t;

  function automatic logic is_reduce(input logic [2:0] fun);
    return (fun == CMP_MAX) || (fun == CMP_MIN);
  endfunction

endpackage

// File: rtl/cmp_core.sv
// rtl/cmp_core.sv - combinational signed/unsigned magnitude comparator
// Purpose: compares a against b in two's-complement or unsigned mode.
// Ports:
//   a, b       in  WIDTH : operands
//   signed_en  in  1     : 1 = signed compare, 0 = unsigned
//   eq, gt, lt out 1     : a == b, a > b, a < b
module cmp_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_en,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  assign eq = (a == b);
  assign gt = signed_en ? ($signed(a) > $signed(b)) : (a > b);
  assign lt = signed_en ? ($signed(a) < $signed(b)) : (a < b);

endmodule

// File: rtl/cmp_reduce_u.sv
// rtl/cmp_reduce_u.sv - registered compare unit with streaming MAX/MIN reduction
// Purpose: single-shot EQ/GT/LT/NE compares (one result per accepted beat) and
//          MAX/MIN reductions over bursts of up to MAX_BURST beats, reporting
//          the winning value and its beat index.
// Ports:
//   CLK        in  1     : clock, rising edge
//   RST        in  1     : asynchronous active-low reset
//   C_EN       in  1     : beat valid
//   ALU_fun_CU in  3     : function code
//   SIGNED_EN  in  1     : signed compare mode
//   LAST       in  1     : final beat of a reduction burst
//   IN1, IN2   in  WIDTH : operands (IN1 is the reduction stream)
//   CMP_Out    out WIDTH : result value, held between results
//   CMP_IDX    out IDXW  : reduction winner index, 0 for single-shot
//   CMP_flag   out 1     : one-cycle result-valid pulse
//   CMP_ERR    out 1     : burst overflow, qualified by CMP_flag
module cmp_reduce_u
  import cmp_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int MAX_BURST = 16,
  localparam int IDXW      = $clog2(MAX_BURST)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             C_EN,
  input  logic [2:0]       ALU_fun_CU,
  input  logic             SIGNED_EN,
  input  logic             LAST,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  output logic [WIDTH-1:0] CMP_Out,
  output logic [IDXW-1:0]  CMP_IDX,
  output logic             CMP_flag,
  output logic             CMP_ERR
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(MAX_BURST - 1);

  cmp_state_t       r_state;
  logic             r_is_min;
  logic             r_signed;
  logic [WIDTH-1:0] r_best;
  logic [IDXW-1:0]  r_best_idx;
  logic [IDXW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_out;
  logic [IDXW-1:0]  r_idx;
  logic             r_flag;
  logic             r_err;

  cmp_state_t       w_nxt_state;
  logic             w_nxt_is_min;
  logic             w_nxt_signed;
  logic [WIDTH-1:0] w_nxt_best;
  logic [IDXW-1:0]  w_nxt_best_idx;
  logic [IDXW-1:0]  w_nxt_cnt;
  logic [WIDTH-1:0] w_nxt_out;
  logic [IDXW-1:0]  w_nxt_idx;
  logic             w_nxt_flag;
  logic             w_nxt_err;

  logic [WIDTH-1:0] w_cmp_b;
  logic             w_cmp_signed;
  logic             w_eq;
  logic             w_gt;
  logic             w_lt;
  logic             w_win;
  logic             w_force;
  logic [WIDTH-1:0] w_acc_best;
  logic [IDXW-1:0]  w_acc_idx;

  // One comparator serves both modes: during a burst IN1 is compared against
  // the running best under the latched signedness.
  assign w_cmp_b      = (r_state == ST_ACCUM) ? r_best   : IN2;
  assign w_cmp_signed = (r_state == ST_ACCUM) ? r_signed : SIGNED_EN;

  cmp_core #(.WIDTH(WIDTH)) u_core (
    .a         (IN1),
    .b         (w_cmp_b),
    .signed_en (w_cmp_signed),
    .eq        (w_eq),
    .gt        (w_gt),
    .lt        (w_lt)
  );

  // Strict win only, so ties keep the earliest index.
  assign w_win      = r_is_min ? w_lt : w_gt;
  assign w_acc_best = w_win ? IN1   : r_best;
  assign w_acc_idx  = w_win ? r_cnt : r_best_idx;
  assign w_force    = (r_cnt == LAST_IDX);

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_is_min   = r_is_min;
    w_nxt_signed   = r_signed;
    w_nxt_best     = r_best;
    w_nxt_best_idx = r_best_idx;
    w_nxt_cnt      = r_cnt;
    w_nxt_out      = r_out;
    w_nxt_idx      = r_idx;
    w_nxt_flag     = 1'b0;
    w_nxt_err      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (C_EN) begin
          if (is_reduce(ALU_fun_CU)) begin
            w_nxt_is_min   = (ALU_fun_CU == CMP_MIN);
            w_nxt_signed   = SIGNED_EN;
            w_nxt_best     = IN1;
            w_nxt_best_idx = '0;
            w_nxt_cnt      = IDXW'(1);
            if (LAST) begin
              w_nxt_out  = IN1;
              w_nxt_idx  = '0;
              w_nxt_flag = 1'b1;
              w_nxt_cnt  = '0;
            end else begin
              w_nxt_state = ST_ACCUM;
            end
          end else begin
            w_nxt_out = '0;
            case (ALU_fun_CU)
              CMP_EQ:           if (w_eq)  w_nxt_out = WIDTH'(CMP_RES_EQ);
              CMP_GT:           if (w_gt)  w_nxt_out = WIDTH'(CMP_RES_GT);
              CMP_LT:           if (w_lt)  w_nxt_out = WIDTH'(CMP_RES_LT);
              CMP_NE:           if (!w_eq) w_nxt_out = WIDTH'(CMP_RES_EQ);
              CMP_NOP, CMP_RSV: w_nxt_out = '0;
              default:          w_nxt_out = '0;
            endcase
            w_nxt_idx  = '0;
            w_nxt_flag = 1'b1;
          end
        end
      end

      ST_ACCUM: begin
        if (C_EN) begin
          w_nxt_best     = w_acc_best;
          w_nxt_best_idx = w_acc_idx;
          w_nxt_cnt      = r_cnt + IDXW'(1);
          if (LAST || w_force) begin
            w_nxt_out   = w_acc_best;
            w_nxt_idx   = w_acc_idx;
            w_nxt_flag  = 1'b1;
            w_nxt_err   = w_force && !LAST;
            w_nxt_cnt   = '0;
            w_nxt_state = ST_IDLE;
          end
        end
      end

      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_is_min   <= 1'b0;
      r_signed   <= 1'b0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_cnt      <= '0;
      r_out      <= '0;
      r_idx      <= '0;
      r_flag     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_is_min   <= w_nxt_is_min;
      r_signed   <= w_nxt_signed;
      r_best     <= w_nxt_best;
      r_best_idx <= w_nxt_best_idx;
      r_cnt      <= w_nxt_cnt;
      r_out      <= w_nxt_out;
      r_idx      <= w_nxt_idx;
      r_flag     <= w_nxt_flag;
      r_err      <= w_nxt_err;
    end
  end

  assign CMP_Out  = r_out;
  assign CMP_IDX  = r_idx;
  assign CMP_flag = r_flag;
  assign CMP_ERR  = r_err;

endmodule

// File: doc/cmp_reduce_u.md
# cmp_reduce_u

Parametrised, registered successor to the compare unit. Performs single-shot signed or unsigned comparisons, and also streaming MAX/MIN reductions over bursts of up to `MAX_BURST` operands. For reductions it reports both the winning value and its beat index. Sits in the ALU datapath beside the arithmetic/logic units and is driven by the control unit's function code and enable.

## Interface
Parameters:
- `WIDTH`, default 16: operand and result width.
- `MAX_BURST`, default 16: maximum reduction burst length; must be ≥ 2.
- `IDXW`, default `$clog2(MAX_BURST)`: index width; derived, not overridden.

Ports:
- `CLK`  in  1: clock, rising edge.
- `RST`  in  1: reset, asynchronous, active-low.
- `C_EN`  in  1: beat valid; operands and controls are sampled when high.
- `ALU_fun_CU`  in  3: function code, see Operation.
- `SIGNED_EN`  in  1: 1 = two's-complement compare, 0 = unsigned.
- `LAST`  in  1: marks the final beat of a reduction burst; ignored for single-shot functions.
- `IN1`  in  WIDTH: operand A, and the reduction data stream.
- `IN2`  in  WIDTH: operand B; ignored in reductions.
- `CMP_Out`  out  WIDTH: result value; holds between results.
- `CMP_IDX`  out  IDXW: reduction winner beat index; 0 for single-shot results.
- `CMP_flag`  out  1: one-cycle result-valid pulse.
- `CMP_ERR`  out  1: burst overflow; valid when `CMP_flag` is high.

## Operation
Function codes:
- 000 NOP: `CMP_Out` = 0.
- 001 EQ: `CMP_Out` = 1 if `IN1` == `IN2`, else 0.
- 010 GT: `CMP_Out` = 2 if `IN1` > `IN2`, else 0.
- 011 LT: `CMP_Out` = 3 if `IN1` < `IN2`, else 0.
- 100 NE: `CMP_Out` = 1 if `IN1` != `IN2`, else 0.
- 101 MAX: reduction.
- 110 MIN: reduction.
- 111 reserved: behaves as NOP.

Single-shot codes (000–100, 111):
- Accepted only in IDLE.
- Every accepted beat produces a `CMP_flag` pulse.

State machine:
- IDLE:
  - `C_EN` with a single-shot code → result registered; stay in IDLE.
  - `C_EN` with MAX/MIN → latch function and `SIGNED_EN`; best = `IN1`, best_idx = 0, cnt = 1.
  - If `LAST` is also high → emit immediately (single-element burst); otherwise go to ACCUM.
- ACCUM:
  - Every `C_EN` beat is a reduction beat using the latched function; `ALU_fun_CU` and `SIGNED_EN` are ignored.
  - Candidate `IN1` replaces best only on a strict win (`>` for MAX, `<` for MIN). Ties keep the earliest index.
  - best_idx takes the value of cnt; cnt increments.
  - `LAST`, or beat index == `MAX_BURST`-1, → emit and return to IDLE. Forced termination sets `CMP_ERR` = 1 unless `LAST` was also high.
  - `C_EN` low → hold state; gaps are allowed.
- Emit: `CMP_Out` = final best, including the terminating beat; `CMP_IDX` = best_idx; `CMP_flag` = 1.
- Signed compare: operands are treated as `$signed` when the effective signed mode is 1. Comparison only; no arithmetic, so no overflow is possible.

## Timing
- Reset (async, `RST` low): `CMP_Out` = 0, `CMP_IDX` = 0, `CMP_flag` = 0, `CMP_ERR` = 0, state IDLE, internal best/cnt = 0.
- Reset mid-burst discards the burst; no flag is produced.
- Single-shot latency is 1 cycle: the beat is sampled at edge N and `CMP_flag`/`CMP_Out` are valid after edge N.
- Back-to-back single-shot beats give one result per cycle.
- Reduction latency: the result is valid in the cycle after the edge that samples the terminating beat.
- The FSM returns to IDLE on that same edge, so a new beat is accepted in the very next cycle.
- `CMP_flag` and `CMP_ERR` are single-cycle pulses. `CMP_Out` and `CMP_IDX` hold until the next result.
- No backpressure: the unit is always ready.

## Structure
- `cmp_pkg`: function-code localparams (`CMP_NOP` … `CMP_MIN`), FSM state enum (`ST_IDLE`, `ST_ACCUM`), result constants 1/2/3.
- Sub-module `cmp_core`: combinational, `WIDTH`-parametrised, inputs a, b and signed_en, outputs eq/gt/lt.
  - One instance serves single-shot (a=`IN1`, b=`IN2`) and reduction (a=`IN1`, b=best) through an operand mux.
- Top: FSM, best/idx/cnt registers, output registers.

## Test plan
- Reset values: assert `RST` low mid-run → all outputs 0 immediately, asynchronously. Release, then send EQ 5,5 → `CMP_Out` = 1, `CMP_flag` = 1 one cycle later.
- Signed vs unsigned: GT with `IN1` = 16'hFFFF, `IN2` = 1 → `CMP_Out` = 2 when `SIGNED_EN` = 0; `CMP_Out` = 0 when `SIGNED_EN` = 1. LT in the signed case → 3.
- MAX burst 3, 9, 9, 4 (`LAST` on the 4th beat, `C_EN` gap after beat 2) → `CMP_Out` = 9, `CMP_IDX` = 1 (tie keeps earliest), `CMP_ERR` = 0, one flag pulse.
- MIN signed burst with `ALU_fun_CU` changed to EQ mid-burst: 7, −2, 5, −2 with `LAST` → `CMP_Out` = 16'hFFFE, `CMP_IDX` = 1 (function change ignored).
- Overflow: MAX_BURST = 4, MAX burst of 6 beats with no `LAST` → emit after beat 3 with `CMP_ERR` = 1. Beats 4–5 form a new burst.
- Single-element burst: MAX with `LAST` on the first beat, `IN1` = 42 → `CMP_Out` = 42, `CMP_IDX` = 0 next cycle. An EQ beat in the following cycle is accepted and produces a result.
